// File: rtl/dispatch_pkg.sv
// dispatch_pkg: opcodes, FU id type and RS/ROB write-packet layouts for the dispatch stage
package dispatch_pkg;
  localparam int DEF_NUM_PREGS = 64;
  localparam int DEF_PW = $clog2(DEF_NUM_PREGS);
  localparam int DEF_XLEN = 32;
  localparam int DEF_NUM_ALU = 2;
  // rob_idx field holds indices of any ROB up to 32 entries; smaller ROBs zero-extend
  localparam int ROB_IDX_W = 5;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  typedef logic [$clog2(DEF_NUM_ALU+1)-1:0] fu_id_t;
  typedef struct packed {
    logic [6:0] opcode;
    logic [DEF_PW-1:0] prd;
    logic [DEF_PW-1:0] prs1;
    logic rdy1;
    logic [DEF_PW-1:0] prs2;
    logic rdy2;
    logic [DEF_XLEN-1:0] imm;
    logic [ROB_IDX_W-1:0] rob_idx;
    fu_id_t fu_id;
  } rs_entry_t;
  typedef struct packed {
    logic [DEF_PW-1:0] prd;
    logic [DEF_PW-1:0] prd_old;
    logic is_store;
  } rob_entry_t;
  function automatic logic is_mem(input logic [6:0] op);
    return op == OP_LOAD || op == OP_STORE;
  endfunction
endpackage

// File: rtl/dispatch_stage_prio_enc_free.sv
// prio_enc_free: index of the lowest clear bit in busy, with found flag
module prio_enc_free #(
  parameter int N = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  busy,
  output logic [IW-1:0] idx,
  output logic          found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (!busy[i]) begin
        idx = IW'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/dispatch_stage.sv
// dispatch_stage: allocates RS slot + ROB tail per renamed instruction and emits registered write packets
module dispatch_stage import dispatch_pkg::*; #(
  parameter int RS_DEPTH = 16,
  parameter int ROB_DEPTH = 32,
  parameter int NUM_PREGS = DEF_NUM_PREGS,
  parameter int NUM_ALU = DEF_NUM_ALU,
  parameter int XLEN = DEF_XLEN,
  localparam int PW = $clog2(NUM_PREGS),
  localparam int RW = $clog2(RS_DEPTH),
  localparam int HW = $clog2(ROB_DEPTH),
  localparam int RRW = NUM_ALU > 1 ? $clog2(NUM_ALU) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [PW-1:0]        in_prs1,
  input  logic [PW-1:0]        in_prs2,
  input  logic [PW-1:0]        in_prd,
  input  logic [PW-1:0]        in_prd_old,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [NUM_PREGS-1:0] preg_ready,
  input  logic                 wb_valid,
  input  logic [PW-1:0]        wb_preg,
  input  logic [RS_DEPTH-1:0]  rs_release,
  input  logic                 rob_commit,
  input  logic                 flush,
  output logic                 rs_wr_en,
  output logic [RW-1:0]        rs_wr_idx,
  output rs_entry_t            rs_wr_data,
  output logic                 rob_wr_en,
  output logic [HW-1:0]        rob_wr_idx,
  output rob_entry_t           rob_wr_data,
  output logic [HW-1:0]        rob_head,
  output logic [HW:0]          rob_count
);
  logic [RS_DEPTH-1:0] rs_busy;
  logic [HW-1:0] tail;
  logic [RRW-1:0] rr_ptr;
  logic [RW-1:0] slot;
  logic slot_found, accept, do_commit, rdy1, rdy2, mem_op;
  rs_entry_t rs_pkt;
  rob_entry_t rob_pkt;

  prio_enc_free #(.N(RS_DEPTH)) u_free (.busy(rs_busy), .idx(slot), .found(slot_found));

  // Readiness looks only at pre-update occupancy, so same-cycle release/commit never opens a slot
  assign in_ready = !reset && !flush && slot_found && rob_count != (HW+1)'(ROB_DEPTH);
  assign accept = in_valid && in_ready;
  assign do_commit = rob_commit && rob_count != '0;
  assign mem_op = is_mem(in_opcode);
  assign rdy1 = in_prs1 == '0 || preg_ready[in_prs1] || (wb_valid && wb_preg == in_prs1);
  assign rdy2 = in_prs2 == '0 || preg_ready[in_prs2] || (wb_valid && wb_preg == in_prs2);
  assign rs_pkt = '{opcode: in_opcode, prd: in_prd, prs1: in_prs1, rdy1: rdy1, prs2: in_prs2,
                    rdy2: rdy2, imm: in_imm, rob_idx: ROB_IDX_W'(tail),
                    fu_id: mem_op ? fu_id_t'(NUM_ALU) : fu_id_t'(rr_ptr)};
  assign rob_pkt = '{prd: in_prd, prd_old: in_prd_old, is_store: in_opcode == OP_STORE};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rs_busy <= '0;
      rob_head <= '0;
      tail <= '0;
      rob_count <= '0;
      rs_wr_en <= 1'b0;
      rob_wr_en <= 1'b0;
      if (reset) begin
        rr_ptr <= '0;
        rs_wr_idx <= '0;
        rs_wr_data <= '0;
        rob_wr_idx <= '0;
        rob_wr_data <= '0;
      end
    end else begin
      rs_busy <= (rs_busy & ~rs_release) | (accept ? RS_DEPTH'(1) << slot : '0);
      rob_count <= rob_count + (HW+1)'(accept) - (HW+1)'(do_commit);
      rs_wr_en <= accept;
      rob_wr_en <= accept;
      if (do_commit) rob_head <= rob_head + 1'b1;
      if (accept) begin
        tail <= tail + 1'b1;
        rs_wr_idx <= slot;
        rs_wr_data <= rs_pkt;
        rob_wr_idx <= tail;
        rob_wr_data <= rob_pkt;
      end
      if (accept && !mem_op) rr_ptr <= rr_ptr == RRW'(NUM_ALU - 1) ? '0 : rr_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed checks of allocation, readiness, FU choice, stalls, flush and ROB wrap
module tb_dispatch_stage;
  import dispatch_pkg::*;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  logic clk = 1'b0, reset, in_valid, wb_valid, rob_commit, flush;
  logic [6:0] in_opcode;
  logic [5:0] in_prs1, in_prs2, in_prd, in_prd_old, wb_preg;
  logic [31:0] in_imm;
  logic [63:0] preg_ready;
  logic [15:0] rs_release;
  logic a_in_ready, a_rs_wr_en, a_rob_wr_en, b_in_ready, b_rs_wr_en, b_rob_wr_en;
  logic [3:0] a_rs_wr_idx, b_rs_wr_idx;
  logic [4:0] a_rob_wr_idx, a_rob_head;
  logic [5:0] a_rob_count;
  logic [1:0] b_rob_wr_idx, b_rob_head;
  logic [2:0] b_rob_count;
  rs_entry_t a_rs_wr_data, b_rs_wr_data;
  rob_entry_t a_rob_wr_data, b_rob_wr_data;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dispatch_stage u_a (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_opcode(in_opcode), .in_prs1(in_prs1), .in_prs2(in_prs2), .in_prd(in_prd),
    .in_prd_old(in_prd_old), .in_imm(in_imm), .preg_ready(preg_ready), .wb_valid(wb_valid),
    .wb_preg(wb_preg), .rs_release(rs_release), .rob_commit(rob_commit), .flush(flush),
    .rs_wr_en(a_rs_wr_en), .rs_wr_idx(a_rs_wr_idx), .rs_wr_data(a_rs_wr_data),
    .rob_wr_en(a_rob_wr_en), .rob_wr_idx(a_rob_wr_idx), .rob_wr_data(a_rob_wr_data),
    .rob_head(a_rob_head), .rob_count(a_rob_count));

  dispatch_stage #(.ROB_DEPTH(4)) u_b (.clk(clk), .reset(reset), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_opcode(in_opcode), .in_prs1(in_prs1), .in_prs2(in_prs2),
    .in_prd(in_prd), .in_prd_old(in_prd_old), .in_imm(in_imm), .preg_ready(preg_ready),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .rs_release(rs_release), .rob_commit(rob_commit),
    .flush(flush), .rs_wr_en(b_rs_wr_en), .rs_wr_idx(b_rs_wr_idx), .rs_wr_data(b_rs_wr_data),
    .rob_wr_en(b_rob_wr_en), .rob_wr_idx(b_rob_wr_idx), .rob_wr_data(b_rob_wr_data),
    .rob_head(b_rob_head), .rob_count(b_rob_count));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [5:0] s1, input logic [5:0] s2,
                       input logic [5:0] d, input logic [5:0] dold, input logic [31:0] imm);
    in_valid = 1'b1;
    in_opcode = op;
    in_prs1 = s1;
    in_prs2 = s2;
    in_prd = d;
    in_prd_old = dold;
    in_imm = imm;
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; wb_valid = 1'b0; rob_commit = 1'b0; flush = 1'b0;
    in_opcode = '0; in_prs1 = '0; in_prs2 = '0; in_prd = '0; in_prd_old = '0; wb_preg = '0;
    in_imm = '0; preg_ready = '0; rs_release = '0;
    tick(); tick();
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_rs_wr_en", a_rs_wr_en, 0);
    chk("rst_rob_count", a_rob_count, 0);
    chk("rst_rob_head", a_rob_head, 0);
    chk("rst_rs_data_zero", a_rs_wr_data == '0, 1);
    reset = 1'b0;
    preg_ready = 64'h8;
    #1 chk("idle_in_ready", a_in_ready, 1);
    issue(OP_ALU, 6'd3, 6'd5, 6'd10, 6'd4, 32'h1234);
    chk("op1_rs_wr_en", a_rs_wr_en, 1);
    chk("op1_rs_idx", a_rs_wr_idx, 0);
    chk("op1_rdy1", a_rs_wr_data.rdy1, 1);
    chk("op1_rdy2", a_rs_wr_data.rdy2, 0);
    chk("op1_fu", a_rs_wr_data.fu_id, 0);
    chk("op1_imm", a_rs_wr_data.imm, 32'h1234);
    chk("op1_rob_en", a_rob_wr_en, 1);
    chk("op1_rob_idx", a_rob_wr_idx, 0);
    chk("op1_rob_prd", a_rob_wr_data.prd, 10);
    chk("op1_rob_prd_old", a_rob_wr_data.prd_old, 4);
    chk("op1_count", a_rob_count, 1);
    wb_valid = 1'b1; wb_preg = 6'd5;
    issue(OP_ALU, 6'd0, 6'd5, 6'd11, 6'd2, 32'h0);
    chk("wake_rdy2", a_rs_wr_data.rdy2, 1);
    chk("wake_rdy1_p0", a_rs_wr_data.rdy1, 1);
    chk("wake_rs_idx", a_rs_wr_idx, 1);
    chk("wake_fu", a_rs_wr_data.fu_id, 1);
    chk("wake_rob_ptr", a_rs_wr_data.rob_idx, 1);
    wb_valid = 1'b0; preg_ready = '0;
    issue(OP_ALU, 6'd7, 6'd0, 6'd12, 6'd3, 32'h0);
    chk("p0_rdy1", a_rs_wr_data.rdy1, 0);
    chk("p0_rdy2", a_rs_wr_data.rdy2, 1);
    chk("alu3_fu", a_rs_wr_data.fu_id, 0);
    issue(OP_LOAD, 6'd1, 6'd2, 6'd13, 6'd4, 32'h8);
    chk("load_fu", a_rs_wr_data.fu_id, 2);
    chk("load_not_store", a_rob_wr_data.is_store, 0);
    chk("load_rs_idx", a_rs_wr_idx, 3);
    issue(OP_ALU, 6'd1, 6'd2, 6'd14, 6'd5, 32'h0);
    chk("alu_after_load_fu", a_rs_wr_data.fu_id, 1);
    issue(OP_STORE, 6'd1, 6'd2, 6'd0, 6'd0, 32'h4);
    chk("store_fu", a_rs_wr_data.fu_id, 2);
    chk("store_flag", a_rob_wr_data.is_store, 1);
    for (int i = 0; i < 10; i++) issue(OP_ALU, 6'd1, 6'd2, 6'd8, 6'd9, 32'(i));
    chk("fill_last_idx", a_rs_wr_idx, 15);
    in_valid = 1'b0;
    #1 chk("full_in_ready", a_in_ready, 0);
    chk("full_count", a_rob_count, 16);
    in_valid = 1'b1; in_opcode = OP_ALU; rs_release = 16'h0080;
    #1 chk("release_same_cycle_ready", a_in_ready, 0);
    tick();
    chk("release_no_accept", a_rs_wr_en, 0);
    rs_release = '0;
    #1 chk("release_next_ready", a_in_ready, 1);
    tick();
    chk("realloc_en", a_rs_wr_en, 1);
    chk("realloc_idx", a_rs_wr_idx, 7);
    chk("realloc_fu", a_rs_wr_data.fu_id, 0);
    in_valid = 1'b0;
    #1 chk("refull_ready", a_in_ready, 0);
    rob_commit = 1'b1;
    tick();
    chk("commit_head", a_rob_head, 1);
    chk("commit_count", a_rob_count, 16);
    rob_commit = 1'b0; rs_release = 16'h0008;
    tick();
    rs_release = '0; in_valid = 1'b1; flush = 1'b1;
    #1 chk("flush_in_ready", a_in_ready, 0);
    tick();
    chk("flush_rs_en", a_rs_wr_en, 0);
    chk("flush_rob_en", a_rob_wr_en, 0);
    chk("flush_count", a_rob_count, 0);
    chk("flush_head", a_rob_head, 0);
    flush = 1'b0;
    issue(OP_ALU, 6'd1, 6'd2, 6'd3, 6'd4, 32'h0);
    chk("post_flush_rs_idx", a_rs_wr_idx, 0);
    chk("post_flush_rob_idx", a_rob_wr_idx, 0);
    chk("post_flush_rr_held", a_rs_wr_data.fu_id, 1);
    issue(OP_ALU, 6'd1, 6'd2, 6'd3, 6'd4, 32'h0);
    chk("post_flush_rs_idx2", a_rs_wr_idx, 1);
    in_valid = 1'b0; reset = 1'b1;
    tick(); tick();
    chk("midrst_rs_en", a_rs_wr_en, 0);
    chk("midrst_rs_idx", a_rs_wr_idx, 0);
    reset = 1'b0; rob_commit = 1'b1;
    tick();
    chk("empty_commit_count", b_rob_count, 0);
    chk("empty_commit_head", b_rob_head, 0);
    rob_commit = 1'b0;
    issue(OP_ALU, 6'd1, 6'd2, 6'd20, 6'd21, 32'h0);
    chk("rst_rr_fu", b_rs_wr_data.fu_id, 0);
    chk("b_rob_idx0", b_rob_wr_idx, 0);
    issue(OP_ALU, 6'd1, 6'd2, 6'd22, 6'd23, 32'h0);
    issue(OP_ALU, 6'd1, 6'd2, 6'd24, 6'd25, 32'h0);
    issue(OP_ALU, 6'd1, 6'd2, 6'd26, 6'd27, 32'h0);
    chk("b_rob_idx3", b_rob_wr_idx, 3);
    chk("b_full_count", b_rob_count, 4);
    rob_commit = 1'b1;
    #1 chk("b_commit_same_ready", b_in_ready, 0);
    tick();
    chk("b_no_accept", b_rob_wr_en, 0);
    chk("b_commit_count", b_rob_count, 3);
    chk("b_commit_head", b_rob_head, 1);
    rob_commit = 1'b0;
    #1 chk("b_ready_after_commit", b_in_ready, 1);
    tick();
    chk("b_wrap_en", b_rob_wr_en, 1);
    chk("b_wrap_idx", b_rob_wr_idx, 0);
    chk("b_wrap_rob_field", b_rs_wr_data.rob_idx, 0);
    chk("b_wrap_count", b_rob_count, 4);
    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
